// File: rtl/cr_pkg.sv
// Shared types and constants for the w80386dx control register file:
// CR indices, CR0 bit positions, writable masks and the flush FSM states.
package cr_pkg;

    typedef enum logic [2:0] {
        CR0, CR1, CR2, CR3, CR4, CR5, CR6, CR7
    } cr_index_e;

    localparam int CR0_PE = 0;
    localparam int CR0_MP = 1;
    localparam int CR0_EM = 2;
    localparam int CR0_TS = 3;
    localparam int CR0_R  = 4;
    localparam int CR0_PG = 31;

    // Masks are built at this width and truncated to DATA_WIDTH by the user.
    localparam int CR_MAX_W = 64;

    typedef enum logic {
        IDLE,
        FLUSH
    } flush_state_e;

    function automatic logic [CR_MAX_W-1:0] cr_wmask(input cr_index_e idx,
                                                     input int dw,
                                                     input int page_shift);
        logic [CR_MAX_W-1:0] ones;
        logic [CR_MAX_W-1:0] m;
        ones = '1;
        m    = '0;
        case (idx)
            CR0: begin
                m[CR0_PG]        = 1'b1;
                m[CR0_R:CR0_PE]  = '1;
            end
            CR2:     m = ones >> (CR_MAX_W - dw);
            CR3:     m = (ones >> (CR_MAX_W - dw)) & (ones << page_shift);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/control_register_file.sv
// CR0-CRn register file: masked software writes with legality checks,
// hardware CR2/TS update paths and a paging-cache flush handshake.
module control_register_file
    import cr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 8,
    parameter int PAGE_SHIFT = 12
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [$clog2(REG_COUNT)-1:0]   wr_index,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           wr_error,
    input  logic [$clog2(REG_COUNT)-1:0]   rd_index,
    output logic [DATA_WIDTH-1:0]          rd_data,
    input  logic                           pf_valid,
    input  logic [DATA_WIDTH-1:0]          pf_linear_addr,
    input  logic                           ts_set,
    input  logic                           clts,
    output logic                           tlb_flush_req,
    input  logic                           tlb_flush_ack,
    output logic                           PE,
    output logic                           MP,
    output logic                           EM,
    output logic                           TS,
    output logic                           R,
    output logic                           PG,
    output logic [DATA_WIDTH-PAGE_SHIFT-1:0] page_directory_base
);

    localparam int IW = $clog2(REG_COUNT);

    localparam logic [DATA_WIDTH-1:0] WMASK_CR0 = DATA_WIDTH'(cr_wmask(CR0, DATA_WIDTH, PAGE_SHIFT));
    localparam logic [DATA_WIDTH-1:0] WMASK_CR2 = DATA_WIDTH'(cr_wmask(CR2, DATA_WIDTH, PAGE_SHIFT));
    localparam logic [DATA_WIDTH-1:0] WMASK_CR3 = DATA_WIDTH'(cr_wmask(CR3, DATA_WIDTH, PAGE_SHIFT));

    // Only CR0, CR2 and CR3 have storage; every other index is reserved.
    logic [DATA_WIDTH-1:0] cr0, cr2, cr3;
    logic [DATA_WIDTH-1:0] cr0_nxt, cr2_nxt, cr3_nxt;
    logic [DATA_WIDTH-1:0] wmask, old_val, new_val, rd_next;
    logic                  sel0, sel2, sel3, accept, cr0_illegal, reserved;
    logic                  wr_ok, wr_reject, flush_start;
    flush_state_e          state, state_nxt;

    always_comb begin
        sel0        = (wr_index == IW'(CR0));
        sel2        = (wr_index == IW'(CR2));
        sel3        = (wr_index == IW'(CR3));
        reserved    = ~(sel0 | sel2 | sel3);
        accept      = wr_valid & wr_ready;

        wmask   = '0;
        old_val = '0;
        if (sel0) begin
            wmask   = WMASK_CR0;
            old_val = cr0;
        end else if (sel2) begin
            wmask   = WMASK_CR2;
            old_val = cr2;
        end else if (sel3) begin
            wmask   = WMASK_CR3;
            old_val = cr3;
        end
        new_val = (old_val & ~wmask) | (wr_data & wmask);

        cr0_illegal = sel0 & new_val[CR0_PG] & ~new_val[CR0_PE];
        wr_reject   = accept & (reserved | cr0_illegal);
        wr_ok       = accept & ~reserved & ~cr0_illegal;
        flush_start = wr_ok & (sel3 | (sel0 & ((new_val[CR0_PG] ^ cr0[CR0_PG]) |
                                               (new_val[CR0_PE] ^ cr0[CR0_PE]))));
    end

    // Hardware paths are layered on top of the software write result.
    always_comb begin
        cr0_nxt = (wr_ok & sel0) ? new_val : cr0;
        if (ts_set)
            cr0_nxt[CR0_TS] = 1'b1;
        else if (clts)
            cr0_nxt[CR0_TS] = 1'b0;

        cr2_nxt = (wr_ok & sel2) ? new_val : cr2;
        if (pf_valid)
            cr2_nxt = pf_linear_addr;

        cr3_nxt = (wr_ok & sel3) ? new_val : cr3;
    end

    always_comb begin
        rd_next = '0;
        if (rd_index == IW'(CR0))
            rd_next = cr0;
        else if (rd_index == IW'(CR2))
            rd_next = cr2;
        else if (rd_index == IW'(CR3))
            rd_next = cr3;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cr0      <= '0;
            cr2      <= '0;
            cr3      <= '0;
            rd_data  <= '0;
            wr_error <= 1'b0;
        end else begin
            cr0      <= cr0_nxt;
            cr2      <= cr2_nxt;
            cr3      <= cr3_nxt;
            rd_data  <= rd_next;
            wr_error <= wr_reject;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_start)   state_nxt = FLUSH;
            FLUSH:   if (tlb_flush_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tlb_flush_req = (state == FLUSH);
        wr_ready      = (state == IDLE);
    end

    assign PE = cr0[CR0_PE];
    assign MP = cr0[CR0_MP];
    assign EM = cr0[CR0_EM];
    assign TS = cr0[CR0_TS];
    assign R  = cr0[CR0_R];
    assign PG = cr0[CR0_PG];
    assign page_directory_base = cr3[DATA_WIDTH-1:PAGE_SHIFT];

endmodule

// File: tb/tb_control_register_file.sv
// Bench for control_register_file: directed vector table, hand-written
// corner sequences, then random traffic against an architectural model.
module tb_control_register_file;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_index = '0;
    logic [31:0] wr_data = '0;
    logic        wr_error;
    logic [2:0]  rd_index = '0;
    logic [31:0] rd_data;
    logic        pf_valid = 1'b0;
    logic [31:0] pf_linear_addr = '0;
    logic        ts_set = 1'b0;
    logic        clts = 1'b0;
    logic        tlb_flush_req;
    logic        tlb_flush_ack = 1'b0;
    logic        PE, MP, EM, TS, R, PG;
    logic [19:0] page_directory_base;

    int checks = 0;
    int failures = 0;

    control_register_file dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
        .wr_data(wr_data), .wr_error(wr_error),
        .rd_index(rd_index), .rd_data(rd_data),
        .pf_valid(pf_valid), .pf_linear_addr(pf_linear_addr),
        .ts_set(ts_set), .clts(clts),
        .tlb_flush_req(tlb_flush_req), .tlb_flush_ack(tlb_flush_ack),
        .PE(PE), .MP(MP), .EM(EM), .TS(TS), .R(R), .PG(PG),
        .page_directory_base(page_directory_base)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_flush;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic sw_write(input logic [2:0] idx, input logic [31:0] d);
        @(negedge clock);
        wr_valid = 1'b1;
        wr_index = idx;
        wr_data  = d;
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
        @(negedge clock);
        rd_index = idx;
        @(negedge clock);
        chk(name, rd_data, exp);
    endtask

    // Called right after the write's accept edge.
    task automatic flush_chk(input string name, input logic exp);
        chk({name, "_req"}, {31'b0, tlb_flush_req}, {31'b0, exp});
        chk({name, "_ready"}, {31'b0, wr_ready}, {31'b0, ~exp});
        if (exp) begin
            @(negedge clock);
            chk({name, "_req_held"}, {31'b0, tlb_flush_req}, 32'd1);
            tlb_flush_ack = 1'b1;
            @(negedge clock);
            tlb_flush_ack = 1'b0;
            chk({name, "_req_done"}, {31'b0, tlb_flush_req}, 32'd0);
            chk({name, "_ready_done"}, {31'b0, wr_ready}, 32'd1);
        end
    endtask

    // Architectural reference state for the random phase.
    logic [31:0] m_cr[8];
    bit          m_flush;
    logic [31:0] m_rd;
    bit          m_err;

    function automatic logic [31:0] arch_mask(input int idx);
        case (idx)
            0:       return 32'h8000_001F;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'hFFFF_F000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input bit wv, input int idx, input logic [31:0] d,
                              input int ri, input bit pf, input logic [31:0] pa,
                              input bit ts, input bit cl, input bit ack);
        logic [31:0] mask, nv;
        bit start_flush;
        start_flush = 0;
        m_rd  = arch_mask(ri) != 0 ? m_cr[ri] : 32'h0;
        m_err = 0;
        if (wv && !m_flush) begin
            mask = arch_mask(idx);
            nv   = (m_cr[idx] & ~mask) | (d & mask);
            if (mask == 0 || (idx == 0 && nv[31] && !nv[0])) begin
                m_err = 1;
            end else begin
                start_flush = (idx == 3) || (idx == 0 && ((nv ^ m_cr[0]) & 32'h8000_0001) != 0);
                m_cr[idx] = nv;
            end
        end
        if (pf) m_cr[2] = pa;
        if (ts) m_cr[0][3] = 1'b1;
        else if (cl) m_cr[0][3] = 1'b0;
        if (m_flush) m_flush = !ack;
        else m_flush = start_flush;
    endtask

    initial begin
        vecs[0] = '{3'd3, 32'h1234_5FFF, 32'h1234_5000, 1'b0, 1'b1};
        vecs[1] = '{3'd0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{3'd0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b1};
        vecs[3] = '{3'd2, 32'h0000_0ABC, 32'h0000_0ABC, 1'b0, 1'b0};
        vecs[4] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{3'd1, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{3'd0, 32'h8000_0013, 32'h8000_0013, 1'b0, 1'b0};
        vecs[7] = '{3'd0, 32'hFFFF_FFFF, 32'h8000_001F, 1'b0, 1'b0};
        vecs[8] = '{3'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[9] = '{3'd7, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0};

        // Reset state
        #12 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) read_chk($sformatf("reset_rd%0d", i), 3'(i), 32'h0);
        chk("reset_pe", {31'b0, PE}, 32'd0);
        chk("reset_pg", {31'b0, PG}, 32'd0);
        chk("reset_ready", {31'b0, wr_ready}, 32'd1);
        chk("reset_flush", {31'b0, tlb_flush_req}, 32'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            sw_write(vecs[i].idx, vecs[i].data);
            chk($sformatf("vec%0d_err", i), {31'b0, wr_error}, {31'b0, vecs[i].exp_err});
            flush_chk($sformatf("vec%0d_flush", i), vecs[i].exp_flush);
            read_chk($sformatf("vec%0d_rd", i), vecs[i].idx, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err_gone", i), {31'b0, wr_error}, 32'd0);
            if (i == 0) chk("pdb", {12'b0, page_directory_base}, 32'h0001_2345);
            if (i == 2) chk("pe_pg_on", {30'b0, PG, PE}, 32'd3);
        end

        // Page fault wins over a same-cycle CR2 write
        @(negedge clock);
        wr_valid = 1'b1; wr_index = 3'd2; wr_data = 32'h1;
        pf_valid = 1'b1; pf_linear_addr = 32'hDEAD_B000;
        @(negedge clock);
        wr_valid = 1'b0; pf_valid = 1'b0;
        read_chk("pf_wins", 3'd2, 32'hDEAD_B000);

        // TS set/clear priority and override of a CR0 write
        @(negedge clock);
        ts_set = 1'b1; clts = 1'b1;
        @(negedge clock);
        ts_set = 1'b0; clts = 1'b0;
        chk("ts_both", {31'b0, TS}, 32'd1);
        @(negedge clock);
        clts = 1'b1;
        @(negedge clock);
        clts = 1'b0;
        chk("ts_clts", {31'b0, TS}, 32'd0);
        @(negedge clock);
        wr_valid = 1'b1; wr_index = 3'd0; wr_data = 32'h0000_0002; ts_set = 1'b1;
        @(negedge clock);
        wr_valid = 1'b0; ts_set = 1'b0;
        chk("ts_override", {31'b0, TS}, 32'd1);
        chk("ts_override_mp", {31'b0, MP}, 32'd1);
        chk("ts_override_noflush", {31'b0, tlb_flush_req}, 32'd0);
        read_chk("ts_override_rd", 3'd0, 32'h0000_000A);

        // Async reset in the middle of a flush
        sw_write(3'd3, 32'hABCD_E000);
        chk("midflush_req", {31'b0, tlb_flush_req}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk("async_drop", {31'b0, tlb_flush_req}, 32'd0);
        chk("async_ready", {31'b0, wr_ready}, 32'd1);
        chk("async_cr0", {26'b0, PG, R, TS, EM, MP, PE}, 32'd0);
        chk("async_pdb", {12'b0, page_directory_base}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        read_chk("post_reset_cr2", 3'd2, 32'h0);

        // Random traffic against the architectural model
        for (int i = 0; i < 8; i++) m_cr[i] = 32'h0;
        m_flush = 0;
        @(negedge clock);
        rd_index = 3'd0;
        @(negedge clock);
        m_rd = 32'h0;
        m_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit          wv, pf, ts, cl, ack;
            int          idx, ri;
            logic [31:0] d, pa;
            chk("rnd_rd", rd_data, m_rd);
            chk("rnd_err", {31'b0, wr_error}, {31'b0, m_err});
            chk("rnd_flush", {30'b0, wr_ready, tlb_flush_req}, {30'b0, !m_flush, m_flush});
            chk("rnd_cr0bits", {26'b0, PG, R, TS, EM, MP, PE},
                {26'b0, m_cr[0][31], m_cr[0][4:0]});
            chk("rnd_pdb", {12'b0, page_directory_base}, {12'b0, m_cr[3][31:12]});
            wv  = ($urandom_range(1) == 1);
            idx = $urandom_range(7);
            if ($urandom_range(2) != 0) idx = $urandom_range(3);
            d   = $urandom;
            ri  = $urandom_range(7);
            pf  = ($urandom_range(4) == 0);
            pa  = $urandom;
            ts  = ($urandom_range(5) == 0);
            cl  = ($urandom_range(5) == 0);
            ack = ($urandom_range(2) == 0);
            wr_valid = wv; wr_index = 3'(idx); wr_data = d; rd_index = 3'(ri);
            pf_valid = pf; pf_linear_addr = pa; ts_set = ts; clts = cl;
            tlb_flush_ack = ack;
            model_step(wv, idx, d, ri, pf, pa, ts, cl, ack);
            @(negedge clock);
        end
        wr_valid = 1'b0; pf_valid = 1'b0; ts_set = 1'b0; clts = 1'b0; tlb_flush_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
